// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: DEPTH x HW single-port store with self-initialisation and two-beat 2*HW fetch.
// Optional boot image is loaded during INIT when INSTR_FETCH_MEM_BOOTROM_EN is defined.
module instr_fetch_mem #(
    parameter int HW = 16,
    parameter int AW = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic [AW-1:0]   AR,
    output logic            Ready,
    output logic            Valid,
    output logic [2*HW-1:0] OUT,
    input  logic            Wr_En,
    input  logic [AW-1:0]   Wr_Addr,
    input  logic [HW-1:0]   Wr_Data
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        FETCH_LO,
        FETCH_HI
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   ar_q;
    logic            ready_q;
    logic            valid_q;
    logic [2*HW-1:0] out_q;

    logic [HW-1:0]   mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [HW-1:0]   mem_wdata;
    logic [HW-1:0]   mem_rdata;

`ifdef INSTR_FETCH_MEM_BOOTROM_EN
    function automatic logic [HW-1:0] boot_word(input logic [AW-1:0] a);
        logic [HW-1:0] w;
        w = '0;
        case (int'(a))
            0:  w = HW'(16'h04E8);
            1:  w = HW'(16'h0001);
            2:  w = HW'(16'h0320);
            3:  w = HW'(16'h0002);
            4:  w = HW'(16'h1B8D);
            5:  w = HW'(16'h0004);
            6:  w = HW'(16'h00FF);
            7:  w = HW'(16'h0008);
            8:  w = HW'(16'h2AF1);
            9:  w = HW'(16'h0010);
            10: w = HW'(16'h0003);
            11: w = HW'(16'h0020);
            12: w = HW'(16'h0002);
            13: w = HW'(16'h0040);
            14: w = HW'(16'h0000);
            15: w = HW'(16'h0080);
            16: w = HW'(16'h0009);
            17: w = HW'(16'h0100);
            18: w = HW'(16'h0009);
            19: w = HW'(16'h0200);
            default: w = '0;
        endcase
        return w;
    endfunction
`endif

    // The single memory port is steered by state: init sweep, program load, low half, high half.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mem_we    = 1'b0;
        mem_addr  = ar_q;
        mem_wdata = Wr_Data;
        case (state_q)
            INIT: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
`ifdef INSTR_FETCH_MEM_BOOTROM_EN
                mem_wdata = boot_word(cnt_q);
`else
                mem_wdata = '0;
`endif
            end
            IDLE: begin
                mem_we   = Wr_En;
                mem_addr = Wr_Addr;
            end
            FETCH_LO: mem_addr = ar_q;
            FETCH_HI: mem_addr = ar_q + AW'(1);
            default: ;
        endcase
        mem_rdata = mem[mem_addr];
    end

    // NOTE: storage has no reset; INIT rewrites every location after reset is released.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ar_q    <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    // A write on the same edge as a request wins; the request is dropped.
                    if (!Wr_En && Req) begin
                        ar_q    <= AR;
                        state_q <= FETCH_LO;
                        ready_q <= 1'b0;
                    end
                end
                FETCH_LO: begin
                    out_q[HW-1:0] <= mem_rdata;
                    state_q       <= FETCH_HI;
                end
                FETCH_HI: begin
                    out_q[2*HW-1:HW] <= mem_rdata;
                    state_q          <= IDLE;
                    ready_q          <= 1'b1;
                    valid_q          <= 1'b1;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign Ready = ready_q;
    assign Valid = valid_q;
    assign OUT   = out_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: init timing, fetch latency, program load, wrap, arbitration, reset abort.
// Boot-image expectations are used when INSTR_FETCH_MEM_BOOTROM_EN is defined.
module tb_instr_fetch_mem;

    localparam int HW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Req;
    logic [AW-1:0]   AR;
    logic            Ready;
    logic            Valid;
    logic [2*HW-1:0] OUT;
    logic            Wr_En;
    logic [AW-1:0]   Wr_Addr;
    logic [HW-1:0]   Wr_Data;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_mem #(.HW(HW), .AW(AW)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Req    (Req),
        .AR     (AR),
        .Ready  (Ready),
        .Valid  (Valid),
        .OUT    (OUT),
        .Wr_En  (Wr_En),
        .Wr_Addr(Wr_Addr),
        .Wr_Data(Wr_Data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Count cycles from reset release until Ready rises, watching Valid/OUT stay quiet.
    task automatic wait_init(input string tag);
        int  n;
        logic quiet;
        n     = 0;
        quiet = 1'b1;
        while (!Ready && n < DEPTH + 20) begin
            tick();
            n++;
            if (Valid !== 1'b0 || OUT !== '0) quiet = 1'b0;
        end
        check({tag, "_init_len"}, 32'(n), 32'(DEPTH));
        check({tag, "_init_quiet"}, {31'b0, quiet}, 32'd1);
    endtask

    task automatic write_hw(input logic [AW-1:0] a, input logic [HW-1:0] d);
        Wr_En   = 1'b1;
        Wr_Addr = a;
        Wr_Data = d;
        tick();
        Wr_En = 1'b0;
    endtask

    // Issue one fetch and return the word seen on the Valid cycle; latency is checked.
    task automatic fetch(input string tag, input logic [AW-1:0] a, output logic [31:0] word);
        int n;
        Req = 1'b1;
        AR  = a;
        tick();
        Req = 1'b0;
        n   = 1;
        while (!Valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd3);
        word = OUT;
        tick();
        check({tag, "_pulse"}, {31'b0, Valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int          nv;
        logic [31:0] vout;

        Reset   = 1'b0;
        Req     = 1'b0;
        AR      = '0;
        Wr_En   = 1'b0;
        Wr_Addr = '0;
        Wr_Data = '0;

        repeat (3) tick();
        check("rst_ready", {31'b0, Ready}, 32'd0);
        check("rst_valid", {31'b0, Valid}, 32'd0);
        check("rst_out", OUT, 32'h0);

        Reset = 1'b1;
        wait_init("boot");

`ifdef INSTR_FETCH_MEM_BOOTROM_EN
        fetch("rom0", 10'd0, w);
        check("rom0_out", w, 32'h000104E8);
        fetch("rom8", 10'd8, w);
        check("rom8_out", w, 32'h00102AF1);
`else
        fetch("zero0", 10'd0, w);
        check("zero0_out", w, 32'h00000000);
`endif
        fetch("zero100", 10'd100, w);
        check("zero100_out", w, 32'h00000000);

        write_hw(10'd5, 16'hABCD);
        check("wr_ready", {31'b0, Ready}, 32'd1);
        write_hw(10'd6, 16'h1234);
        fetch("ld5", 10'd5, w);
        check("ld5_out", w, 32'h1234ABCD);

        repeat (4) tick();
        check("out_hold", OUT, 32'h1234ABCD);

        write_hw(10'(DEPTH - 1), 16'h00AA);
        write_hw(10'd0, 16'h5500);
        fetch("wrap", 10'(DEPTH - 1), w);
        check("wrap_out", w, 32'h550000AA);

        // Write and request on the same edge: write wins, no fetch starts.
        Wr_En   = 1'b1;
        Wr_Addr = 10'd200;
        Wr_Data = 16'hBEEF;
        Req     = 1'b1;
        AR      = 10'd200;
        tick();
        Wr_En = 1'b0;
        Req   = 1'b0;
        check("coll_ready", {31'b0, Ready}, 32'd1);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Valid) nv++;
        end
        check("coll_novalid", 32'(nv), 32'd0);
        fetch("coll", 10'd200, w);
        check("coll_out", w, 32'h0000BEEF);

        // Req held through the fetch, AR changed and writes attempted while busy: all ignored.
        nv   = 0;
        vout = '0;
        for (int i = 0; i < 8; i++) begin
            Req     = (i < 3);
            AR      = (i == 0) ? 10'd5 : 10'd100;
            Wr_En   = (i == 1 || i == 2);
            Wr_Addr = 10'd6;
            Wr_Data = 16'hFFFF;
            tick();
            if (Valid) begin
                nv++;
                vout = OUT;
            end
        end
        Req   = 1'b0;
        Wr_En = 1'b0;
        check("busy_nvalid", 32'(nv), 32'd1);
        check("busy_out", vout, 32'h1234ABCD);
        fetch("busy_nowr", 10'd6, w);
        check("busy_nowr_out", w, 32'h00001234);

        // Reset during FETCH_HI aborts the fetch and clears OUT immediately.
        Req = 1'b1;
        AR  = 10'd5;
        tick();
        Req = 1'b0;
        tick();
        check("lo_first", OUT, 32'h0000ABCD);
        Reset = 1'b0;
        #1;
        check("abort_out", OUT, 32'h0);
        check("abort_ready", {31'b0, Ready}, 32'd0);
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Valid) nv++;
        end
        check("abort_novalid", 32'(nv), 32'd0);
        Reset = 1'b1;
        wait_init("reinit");
        fetch("reinit5", 10'd5, w);
`ifdef INSTR_FETCH_MEM_BOOTROM_EN
        check("reinit5_out", w, 32'h00FF0004);
`else
        check("reinit5_out", w, 32'h00000000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
